// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two client request/ack ports plus the byte-wide RAM bus of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c0_re, c0_we, c1_re, c1_we;
  logic [ADDR_W-1:0] c0_raddr, c0_waddr, c1_raddr, c1_waddr;
  logic [1:0]        c0_rlen, c0_wlen, c1_rlen, c1_wlen;
  logic [DATA_W-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic              c0_rack, c0_wack, c1_rack, c1_wack;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  modport slave (
    input  c0_re, c0_we, c0_raddr, c0_waddr, c0_rlen, c0_wlen, c0_wdata,
    input  c1_re, c1_we, c1_raddr, c1_waddr, c1_rlen, c1_wlen, c1_wdata,
    output c0_rdata, c0_rack, c0_wack, c1_rdata, c1_rack, c1_wack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
  modport master (
    output c0_re, c0_we, c0_raddr, c0_waddr, c0_rlen, c0_wlen, c0_wdata,
    output c1_re, c1_we, c1_raddr, c1_waddr, c1_rlen, c1_wlen, c1_wdata,
    input  c0_rdata, c0_rack, c0_wack, c1_rdata, c1_rack, c1_wack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serialising two clients' 4-phase requests into byte RAM accesses
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave mem_io
);
  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, ACK} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, len_q, len_d, prev_i;
  logic [1:0]        rack_q, rack_d, wack_q, wack_d, re, we, el_r, el_w, el;
  logic              port_q, port_d, dir_q, dir_d, last_q, last_d, gnt, fin;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdat0_q, rdat0_d, rdat1_q, rdat1_d;
  logic [DATA_W-1:0] rbyte, rfin;
  assign re     = {mem_io.c1_re, mem_io.c0_re};
  assign we     = {mem_io.c1_we, mem_io.c0_we};
  assign el_r   = re & ~rack_q;
  assign el_w   = we & ~wack_q;
  assign el     = el_r | el_w;
  assign gnt    = &el ? ~last_q : el[1];
  assign prev_i = cnt_q - 2'd1;
  assign rbyte  = DATA_W'(mem_io.ram_rdata);
  assign rfin   = rbuf_q | (rbyte << {len_q, 3'b0});
  assign fin    = state_q == RD_LAST || (state_q == WR && cnt_q == len_q);
  // An ack is only raised if the request is still held; it then tracks the request level
  assign rack_d = (rack_q & re) | ({port_q, ~port_q} & {2{fin & ~dir_q}} & re);
  assign wack_d = (wack_q & we) | ({port_q, ~port_q} & {2{fin & dir_q}} & we);
  assign mem_io.ram_en    = state_q == RD || state_q == WR;
  assign mem_io.ram_we    = state_q == WR;
  assign mem_io.ram_addr  = addr_q + ADDR_W'(cnt_q);
  assign mem_io.ram_wdata = 8'(wdata_q >> {cnt_q, 3'b0});
  assign mem_io.c0_rdata  = rdat0_q;
  assign mem_io.c1_rdata  = rdat1_q;
  assign mem_io.c0_rack   = rack_q[0];
  assign mem_io.c1_rack   = rack_q[1];
  assign mem_io.c0_wack   = wack_q[0];
  assign mem_io.c1_wack   = wack_q[1];
  // Grant from IDLE (write beats read within a port), then walk the byte counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    port_d  = port_q;
    dir_d   = dir_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    case (state_q)
      IDLE: if (|el) begin
        state_d = el_w[gnt] ? WR : RD;
        port_d  = gnt;
        last_d  = gnt;
        dir_d   = el_w[gnt];
        cnt_d   = 2'd0;
        rbuf_d  = '0;
        addr_d  = el_w[gnt] ? (gnt ? mem_io.c1_waddr : mem_io.c0_waddr)
                            : (gnt ? mem_io.c1_raddr : mem_io.c0_raddr);
        len_d   = el_w[gnt] ? (gnt ? mem_io.c1_wlen : mem_io.c0_wlen)
                            : (gnt ? mem_io.c1_rlen : mem_io.c0_rlen);
        wdata_d = gnt ? mem_io.c1_wdata : mem_io.c0_wdata;
      end
      RD: begin
        cnt_d   = cnt_q + 2'd1;
        rbuf_d  = cnt_q != 2'd0 ? rbuf_q | (rbyte << {prev_i, 3'b0}) : rbuf_q;
        state_d = cnt_q == len_q ? RD_LAST : RD;
      end
      RD_LAST: begin
        state_d = ACK;
        rdat0_d = port_q ? rdat0_q : rfin;
        rdat1_d = port_q ? rfin : rdat1_q;
      end
      WR: begin
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == len_q ? ACK : WR;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and working registers; reset aborts any access and points last_grant at port1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      len_q   <= 2'd0;
      port_q  <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
      rack_q  <= 2'b00;
      wack_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      port_q  <= port_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
    end
endmodule
